// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids and the
// transaction record carried by each request slot and by the memory port.
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } arb_src_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_txn_t;

  function automatic arb_src_t other_src(input arb_src_t src);
    return (src == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-transaction memory bus: a requester (master) pulses req with the
// transaction fields, the responder (slave) pulses resp with rdata.
interface mem_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  modport master (
    output req, addr, rmask, wmask, wdata,
    input  rdata, resp
  );

  modport slave (
    input  req, addr, rmask, wmask, wdata,
    output rdata, resp
  );
endinterface

// File: rtl/mem_arbiter_req_slot.sv
// One-entry holding register for a requester whose pulse could not be
// granted straight away. load and clear are never asserted together.
module arb_req_slot
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     clear,
  input  mem_txn_t txn_in,
  output logic     valid,
  output mem_txn_t txn
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      txn   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      txn   <= txn_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: imem and dmem share one memory port, one
// transaction in flight, ties alternate starting with dmem after reset.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ARB_IDLE   | nothing in flight; grant a slot or a same-cycle request
// ARB_BUSY_I | fetch transaction issued, waiting for mem.resp
// ARB_BUSY_D | data transaction issued, waiting for mem.resp
module mem_arbiter
  import rv32i_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  imem,
  mem_arbiter_if.slave  dmem,
  mem_arbiter_if.master mem
);

  arb_state_t state, state_nxt;
  arb_src_t   last_grant, last_grant_nxt;
  arb_src_t   grant_src;
  logic       grant;

  mem_txn_t imem_txn_in, dmem_txn_in;
  mem_txn_t islot_txn, dslot_txn;
  mem_txn_t grant_txn, mem_txn_q;
  logic     islot_valid, dslot_valid;
  logic     islot_load, dslot_load;
  logic     islot_clear, dslot_clear;
  logic     cand_i, cand_d;
  logic     imem_in_flight, dmem_in_flight;
  logic     mem_req_q;
  logic     imem_done, dmem_done;

  assign imem_txn_in = '{addr: imem.addr, rmask: imem.rmask,
                         wmask: imem.wmask, wdata: imem.wdata};
  assign dmem_txn_in = '{addr: dmem.addr, rmask: dmem.rmask,
                         wmask: dmem.wmask, wdata: dmem.wdata};

  // A pending slot and a fresh pulse both count; the pulse bypasses the slot.
  assign cand_i = islot_valid | imem.req;
  assign cand_d = dslot_valid | dmem.req;

  // The response cycle already frees the requester, so a pulse there is kept.
  assign imem_in_flight = (state == ARB_BUSY_I) && !mem.resp;
  assign dmem_in_flight = (state == ARB_BUSY_D) && !mem.resp;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant          = 1'b0;
    grant_src      = SRC_IMEM;
    grant_txn      = '0;
    islot_clear    = 1'b0;
    dslot_clear    = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (cand_i || cand_d) begin
          grant = 1'b1;
          if (cand_i && cand_d) begin
            grant_src = other_src(last_grant);
          end else begin
            grant_src = cand_i ? SRC_IMEM : SRC_DMEM;
          end
          last_grant_nxt = grant_src;
          if (grant_src == SRC_IMEM) begin
            grant_txn   = islot_valid ? islot_txn : imem_txn_in;
            islot_clear = islot_valid;
            state_nxt   = ARB_BUSY_I;
          end else begin
            grant_txn   = dslot_valid ? dslot_txn : dmem_txn_in;
            dslot_clear = dslot_valid;
            state_nxt   = ARB_BUSY_D;
          end
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem.resp) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign islot_load = imem.req && !islot_valid && !imem_in_flight &&
                      !(grant && grant_src == SRC_IMEM);
  assign dslot_load = dmem.req && !dslot_valid && !dmem_in_flight &&
                      !(grant && grant_src == SRC_DMEM);

  arb_req_slot u_islot (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (islot_load),
    .clear  (islot_clear),
    .txn_in (imem_txn_in),
    .valid  (islot_valid),
    .txn    (islot_txn)
  );

  arb_req_slot u_dslot (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dslot_load),
    .clear  (dslot_clear),
    .txn_in (dmem_txn_in),
    .valid  (dslot_valid),
    .txn    (dslot_txn)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= SRC_IMEM;
      mem_req_q  <= 1'b0;
      mem_txn_q  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      mem_req_q  <= grant;
      if (grant) begin
        mem_txn_q <= grant_txn;
      end
    end
  end

  assign mem.req   = mem_req_q;
  assign mem.addr  = mem_txn_q.addr;
  assign mem.rmask = mem_txn_q.rmask;
  assign mem.wmask = mem_txn_q.wmask;
  assign mem.wdata = mem_txn_q.wdata;

  assign imem_done  = (state == ARB_BUSY_I) && mem.resp;
  assign dmem_done  = (state == ARB_BUSY_D) && mem.resp;
  assign imem.resp  = imem_done;
  assign dmem.resp  = dmem_done;
  assign imem.rdata = imem_done ? mem.rdata : 32'h0;
  assign dmem.rdata = dmem_done ? mem.rdata : 32'h0;

endmodule
